tokenflow: RTL and testbench

Self-timed-style token source that emits the sequence x·(x+1) for x = 0, 1, 2, … (0, 2, 6, 12, 20, …) over a four-phase req/ack output channel. It sits behind the top-level pin wrapper: req and data drive output pins, and ack arrives asynchronously from an input pin. Internally the block is synchronous to a single clock; each token's value is computed by an on-chip multiplier before being offered.

---
 rtl/tokenflow.sv | 133 +++++++++++++
 tb/tb_tokenflow.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tokenflow.sv
// tokenflow: token source emitting x*(x+1) mod 2^W for x = 0, 1, 2, ...
// over a four-phase req/ack channel. ack is asynchronous and is
// synchronized here before use.
//
// Build option: define TOKENFLOW_INCR_EN to replace the W-cycle shift-add
// multiplier with an incremental accumulator (1-cycle COMPUTE). Token
// values and handshake order are the same in both builds.
//
// Channel handshake (four-phase): data is loaded first, and req rises on
// the same edge, so data is valid whenever req is high. The consumer raises
// ack, and req falls one edge after ack_s is seen high. The consumer then
// drops ack, and one edge after ack_s is seen low the next token begins.
// data is held from req rising until ack_s low has been seen.
module tokenflow #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ack,
    output logic         req,
    output logic [W-1:0] data
);

    typedef enum logic [1:0] {
        COMPUTE = 2'd0,
        OFFER   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t       state;
    state_t       state_next;
    logic         ack_m;
    logic         ack_s;
    logic [W-1:0] x;
    logic [W-1:0] x_inc;
    logic [W-1:0] product;
    logic         compute_done;

    // x+1 is taken in W bits, so the largest x multiplies by zero.
    assign x_inc = x + 1'b1;

    // Two-flop synchronizer for the asynchronous acknowledge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_m <= 1'b0;
            ack_s <= 1'b0;
        end else begin
            ack_m <= ack;
            ack_s <= ack_m;
        end
    end

`ifdef TOKENFLOW_INCR_EN
    logic [W-1:0] p;

    assign product      = p;
    assign compute_done = 1'b1;

    // Running product: (x+1)(x+2) - x(x+1) = 2(x+1), added as x advances.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p <= '0;
        end else if (state == RELEASE && !ack_s) begin
            p <= p + (x_inc << 1);
        end
    end
`else
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    logic [CW-1:0] bit_idx;
    logic [W-1:0]  acc;
    logic [W-1:0]  acc_next;

    // One multiplier bit of (x+1) per cycle; the last cycle's sum is the product.
    assign acc_next     = acc + (x_inc[bit_idx] ? (x << bit_idx) : '0);
    assign product      = acc_next;
    assign compute_done = (bit_idx == CW'(W - 1));

    // Shift-add multiplier state; cleared after each completed product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_idx <= '0;
            acc     <= '0;
        end else if (state == COMPUTE) begin
            if (compute_done) begin
                bit_idx <= '0;
                acc     <= '0;
            end else begin
                bit_idx <= bit_idx + 1'b1;
                acc     <= acc_next;
            end
        end
    end
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= COMPUTE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic for the compute / offer / release cycle.
    always_comb begin
        state_next = state;
        case (state)
            COMPUTE: if (compute_done) state_next = OFFER;
            OFFER:   if (ack_s)        state_next = RELEASE;
            RELEASE: if (!ack_s)       state_next = COMPUTE;
            default:                   state_next = COMPUTE;
        endcase
    end

    // Registered channel outputs and token counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req  <= 1'b0;
            data <= '0;
            x    <= '0;
        end else begin
            req <= (state_next == OFFER);
            if (state == COMPUTE && compute_done) begin
                data <= product;
            end
            if (state == RELEASE && !ack_s) begin
                x <= x_inc;
            end
        end
    end

endmodule

// File: tb/tb_tokenflow.sv
// Directed testbench for tokenflow: a W=16 instance for reset, stall,
// loopback and mid-offer reset, and a W=4 instance for wrap-around.
module tb_tokenflow;

`ifdef TOKENFLOW_INCR_EN
    localparam int LAT16 = 1;
    localparam int LAT4  = 1;
`else
    localparam int LAT16 = 16;
    localparam int LAT4  = 4;
`endif
    localparam int PER16 = LAT16 + 6;
    localparam int PER4  = LAT4 + 6;

    logic        clk;
    logic        rst_n;
    logic        loop16;
    logic        loop4;
    logic        ack_drv16;
    logic        ack_drv4;
    logic        ack16;
    logic        ack4;
    logic        req16;
    logic        req4;
    logic [15:0] data16;
    logic [3:0]  data4;

    int tests_run;
    int tests_failed;
    logic prev16;
    logic prev4;

    assign ack16 = loop16 ? req16 : ack_drv16;
    assign ack4  = loop4  ? req4  : ack_drv4;

    tokenflow #(.W(16)) dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .ack   (ack16),
        .req   (req16),
        .data  (data16)
    );

    tokenflow #(.W(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .ack   (ack4),
        .req   (req4),
        .data  (data4)
    );

    // Clock and initial reset level.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hold reset for a few cycles with both channels idle, release on a negedge.
    task automatic apply_reset();
        loop16    = 1'b0;
        loop4     = 1'b0;
        ack_drv16 = 1'b0;
        ack_drv4  = 1'b0;
        rst_n     = 1'b0;
        repeat (3) @(negedge clk);
        rst_n  = 1'b1;
        prev16 = 1'b0;
        prev4  = 1'b0;
    endtask

    // Wait (bounded) for the next req rising edge on one instance; returns
    // the token and the number of negedges waited.
    task automatic get_tok(input bit sel4, output logic [15:0] val,
                           output int cyc, output bit ok);
        logic r;
        ok  = 1'b0;
        val = '0;
        cyc = 0;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            r = sel4 ? req4 : req16;
            if (r && !(sel4 ? prev4 : prev16)) begin
                val = sel4 ? {12'd0, data4} : data16;
                cyc = i;
                ok  = 1'b1;
            end
            if (sel4) prev4 = r; else prev16 = r;
            if (ok) break;
        end
    endtask

    task automatic test_reset();
        logic [15:0] v;
        int          c;
        bit          ok;
        loop16    = 1'b0;
        loop4     = 1'b0;
        ack_drv16 = 1'b0;
        ack_drv4  = 1'b0;
        rst_n     = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (req16 !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_req: got %b expected 0", req16);
        end
        tests_run++;
        if (data16 !== 16'd0) begin
            tests_failed++;
            $display("FAIL reset_data: got %0d expected 0", data16);
        end
        rst_n  = 1'b1;
        prev16 = 1'b0;
        prev4  = 1'b0;
        get_tok(1'b0, v, c, ok);
        tests_run++;
        if (!ok || c !== LAT16) begin
            tests_failed++;
            $display("FAIL reset_latency: got %0d (seen %0d) expected %0d", c, ok, LAT16);
        end
        tests_run++;
        if (v !== 16'd0) begin
            tests_failed++;
            $display("FAIL reset_first_token: got %0d expected 0", v);
        end
    endtask

    // Continues from test_reset: dut16 is offering token 0 with ack low.
    task automatic test_stall();
        int bad_req;
        int bad_data;
        int fall;
        bad_req  = 0;
        bad_data = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (req16 !== 1'b1) bad_req++;
            if (data16 !== 16'd0) bad_data++;
        end
        tests_run++;
        if (bad_req != 0) begin
            tests_failed++;
            $display("FAIL stall_req_hold: %0d cycles low, expected 0", bad_req);
        end
        tests_run++;
        if (bad_data != 0) begin
            tests_failed++;
            $display("FAIL stall_data_hold: %0d cycles changed, expected 0", bad_data);
        end
        ack_drv16 = 1'b1;
        fall = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (req16 === 1'b0) begin
                fall = i;
                break;
            end
        end
        tests_run++;
        if (fall != 3) begin
            tests_failed++;
            $display("FAIL stall_req_fall: got %0d edges expected 3", fall);
        end
        ack_drv16 = 1'b0;
    endtask

    task automatic test_loopback();
        logic [15:0] v;
        logic [15:0] exp_tok [8];
        int          c;
        int          bad_per;
        bit          ok;
        exp_tok = '{16'd0, 16'd2, 16'd6, 16'd12, 16'd20, 16'd30, 16'd42, 16'd56};
        bad_per = 0;
        apply_reset();
        loop16 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            get_tok(1'b0, v, c, ok);
            tests_run++;
            if (!ok || v !== exp_tok[i]) begin
                tests_failed++;
                $display("FAIL loopback_token%0d: got %0d (seen %0d) expected %0d", i, v, ok, exp_tok[i]);
            end
            if (i > 0 && c != PER16) bad_per++;
        end
        tests_run++;
        if (bad_per != 0) begin
            tests_failed++;
            $display("FAIL loopback_period: %0d periods off, expected all %0d", bad_per, PER16);
        end
    endtask

    task automatic test_reset_mid_offer();
        logic [15:0] v;
        int          c;
        bit          ok;
        apply_reset();
        loop16 = 1'b1;
        get_tok(1'b0, v, c, ok);
        get_tok(1'b0, v, c, ok);
        tests_run++;
        if (!ok || req16 !== 1'b1 || v !== 16'd2) begin
            tests_failed++;
            $display("FAIL mid_offer_setup: req %b token %0d expected req 1 token 2", req16, v);
        end
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (req16 !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_offer_async_req: got %b expected 0", req16);
        end
        tests_run++;
        if (data16 !== 16'd0) begin
            tests_failed++;
            $display("FAIL mid_offer_async_data: got %0d expected 0", data16);
        end
        @(negedge clk);
        rst_n  = 1'b1;
        prev16 = 1'b0;
        get_tok(1'b0, v, c, ok);
        tests_run++;
        if (!ok || v !== 16'd0 || c != LAT16) begin
            tests_failed++;
            $display("FAIL mid_offer_restart: token %0d after %0d cycles, expected 0 after %0d", v, c, LAT16);
        end
    endtask

    task automatic test_wrap();
        logic [15:0] v;
        logic [3:0]  exp_tok [16];
        int          c;
        int          bad_per;
        bit          ok;
        exp_tok = '{4'd0, 4'd2, 4'd6, 4'd12, 4'd4, 4'd14, 4'd10, 4'd8,
                    4'd8, 4'd10, 4'd14, 4'd4, 4'd12, 4'd6, 4'd2, 4'd0};
        bad_per = 0;
        apply_reset();
        loop4 = 1'b1;
        for (int i = 0; i < 34; i++) begin
            get_tok(1'b1, v, c, ok);
            tests_run++;
            if (!ok || v !== {12'd0, exp_tok[i % 16]}) begin
                tests_failed++;
                $display("FAIL wrap_token%0d: got %0d (seen %0d) expected %0d", i, v, ok, exp_tok[i % 16]);
            end
            if (i > 0 && c != PER4) bad_per++;
        end
        tests_run++;
        if (bad_per != 0) begin
            tests_failed++;
            $display("FAIL wrap_period: %0d periods off, expected all %0d", bad_per, PER4);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] v;
        logic [15:0] e;
        int          c;
        int          bad_per;
        bit          ok;
        bad_per = 0;
        apply_reset();
        loop16 = 1'b1;
        for (int i = 0; i < 64; i++) begin
            e = 16'((i * (i + 1)) & 32'hFFFF);
            get_tok(1'b0, v, c, ok);
            tests_run++;
            if (!ok || v !== e) begin
                tests_failed++;
                $display("FAIL b2b_token%0d: got %0d (seen %0d) expected %0d", i, v, ok, e);
            end
            if ((i == 0 && c != LAT16) || (i > 0 && c != PER16)) bad_per++;
        end
        tests_run++;
        if (bad_per != 0) begin
            tests_failed++;
            $display("FAIL b2b_timing: %0d intervals off, expected period %0d", bad_per, PER16);
        end
    endtask

    // Test sequence and final report.
    initial begin
        tests_run    = 0;
        tests_failed = 0;
        prev16       = 1'b0;
        prev4        = 1'b0;
        test_reset();
        test_stall();
        test_loopback();
        test_reset_mid_offer();
        test_wrap();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
